// File: rtl/execute_stage_mc_if.sv
// rtl/execute_stage_mc_if.sv - ID/EX operation handshake and EX/MEM result bundle for execute_stage_mc
// Purpose: groups the upstream operation channel, flush and downstream result channel.
// Ports (by modport):
//   slave  : used by execute_stage_mc; *_i are inputs, *_o are outputs.
//   master : used by the surrounding pipeline (or a bench); directions mirrored.
interface execute_stage_mc_if #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
);
    logic            flush_i;
    logic            valid_i;
    logic            ready_o;
    logic [XLEN-1:0] pc_i;
    logic [XLEN-1:0] rs1_data_i;
    logic [XLEN-1:0] rs2_data_i;
    logic [XLEN-1:0] offset_i;
    logic [4:0]      aluop_i;
    logic            alusrc_i;
    logic [RD_W-1:0] rd_i;
    logic            regwrite_i;
    logic            valid_o;
    logic            ready_i;
    logic [XLEN-1:0] alu_result_o;
    logic [XLEN-1:0] rs2_data_o;
    logic [XLEN-1:0] branch_target_o;
    logic [RD_W-1:0] rd_o;
    logic            regwrite_o;
    logic            branch_taken_o;
    logic            illegal_o;
    logic            busy_o;

    modport slave (
        input  flush_i, valid_i, pc_i, rs1_data_i, rs2_data_i, offset_i,
               aluop_i, alusrc_i, rd_i, regwrite_i, ready_i,
        output ready_o, valid_o, alu_result_o, rs2_data_o, branch_target_o,
               rd_o, regwrite_o, branch_taken_o, illegal_o, busy_o
    );

    modport master (
        output flush_i, valid_i, pc_i, rs1_data_i, rs2_data_i, offset_i,
               aluop_i, alusrc_i, rd_i, regwrite_i, ready_i,
        input  ready_o, valid_o, alu_result_o, rs2_data_o, branch_target_o,
               rd_o, regwrite_o, branch_taken_o, illegal_o, busy_o
    );
endinterface

// File: rtl/execute_stage_mc.sv
// rtl/execute_stage_mc.sv - PSRV32 multi-cycle execute stage with EX/MEM output register
// Purpose: single-cycle ALU/branch evaluation plus optional iterative divide/remainder.
// Optional feature macro: EX_DIV_EN (ops 16-19 use the restoring divider; otherwise illegal).
// Ports:
//   clk_i    : clock, rising edge
//   reset_ni : asynchronous active-low reset
//   bus      : execute_stage_mc_if.slave - operation in (valid/ready), flush,
//              registered result out (valid/ready), busy flag
module execute_stage_mc #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    execute_stage_mc_if.slave   bus
);
    localparam int SH_W = $clog2(XLEN);

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_SLL  = 5'd2;
    localparam logic [4:0] OP_SLT  = 5'd3;
    localparam logic [4:0] OP_SLTU = 5'd4;
    localparam logic [4:0] OP_XOR  = 5'd5;
    localparam logic [4:0] OP_SRL  = 5'd6;
    localparam logic [4:0] OP_SRA  = 5'd7;
    localparam logic [4:0] OP_OR   = 5'd8;
    localparam logic [4:0] OP_AND  = 5'd9;
    localparam logic [4:0] OP_BEQ  = 5'd10;
    localparam logic [4:0] OP_BNE  = 5'd11;
    localparam logic [4:0] OP_BLT  = 5'd12;
    localparam logic [4:0] OP_BGE  = 5'd13;
    localparam logic [4:0] OP_BLTU = 5'd14;
    localparam logic [4:0] OP_BGEU = 5'd15;
`ifdef EX_DIV_EN
    localparam logic [4:0] OP_DIV  = 5'd16;
    localparam logic [4:0] OP_DIVU = 5'd17;
    localparam logic [4:0] OP_REM  = 5'd18;
    localparam logic [4:0] OP_REMU = 5'd19;
`endif

    logic [XLEN-1:0] op2;
    logic [SH_W-1:0] shamt;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] alu_res;
    logic            is_branch;
    logic            is_div;
    logic            is_ill;
    logic            taken;
    logic            rw_single;
    logic            accept;
    logic            out_free;
    logic            idle;
    logic            div_emit;

    logic            valid_q;
    logic [XLEN-1:0] result_q;
    logic [XLEN-1:0] store_q;
    logic [XLEN-1:0] target_q;
    logic [RD_W-1:0] rd_q;
    logic            regwrite_q;
    logic            taken_q;
    logic            illegal_q;

    assign op2    = bus.alusrc_i ? bus.offset_i : bus.rs2_data_i;
    assign shamt  = op2[SH_W-1:0];
    assign target = bus.pc_i + bus.offset_i;

    // Single-cycle decode; branches compare the register operands only.
    always_comb begin
        alu_res   = '0;
        is_branch = 1'b0;
        is_div    = 1'b0;
        is_ill    = 1'b0;
        taken     = 1'b0;
        case (bus.aluop_i)
            OP_ADD:  alu_res = bus.rs1_data_i + op2;
            OP_SUB:  alu_res = bus.rs1_data_i - op2;
            OP_SLL:  alu_res = bus.rs1_data_i << shamt;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(bus.rs1_data_i) < $signed(op2)};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, bus.rs1_data_i < op2};
            OP_XOR:  alu_res = bus.rs1_data_i ^ op2;
            OP_SRL:  alu_res = bus.rs1_data_i >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(bus.rs1_data_i) >>> shamt);
            OP_OR:   alu_res = bus.rs1_data_i | op2;
            OP_AND:  alu_res = bus.rs1_data_i & op2;
            OP_BEQ:  begin is_branch = 1'b1; taken = bus.rs1_data_i == bus.rs2_data_i; end
            OP_BNE:  begin is_branch = 1'b1; taken = bus.rs1_data_i != bus.rs2_data_i; end
            OP_BLT:  begin is_branch = 1'b1; taken = $signed(bus.rs1_data_i) <  $signed(bus.rs2_data_i); end
            OP_BGE:  begin is_branch = 1'b1; taken = $signed(bus.rs1_data_i) >= $signed(bus.rs2_data_i); end
            OP_BLTU: begin is_branch = 1'b1; taken = bus.rs1_data_i <  bus.rs2_data_i; end
            OP_BGEU: begin is_branch = 1'b1; taken = bus.rs1_data_i >= bus.rs2_data_i; end
`ifdef EX_DIV_EN
            OP_DIV, OP_DIVU, OP_REM, OP_REMU: is_div = 1'b1;
`endif
            default: is_ill = 1'b1;
        endcase
    end

    assign rw_single = bus.regwrite_i && !is_branch && !is_ill;

    assign out_free    = !valid_q || bus.ready_i;
    assign bus.ready_o = idle && out_free && !bus.flush_i;
    assign accept      = bus.valid_i && bus.ready_o;

`ifdef EX_DIV_EN
    typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [SH_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] dsr_q;
    logic            neg_quo_q, neg_rem_q, div0_q, is_rem_q;
    logic [XLEN-1:0] div_store_q, div_target_q;
    logic [RD_W-1:0] div_rd_q;
    logic            div_rw_q;

    logic            div_signed, dvd_neg, dsr_neg;
    logic [XLEN-1:0] dvd_mag, dsr_mag;
    logic [XLEN:0]   trial, diff;
    logic [XLEN-1:0] quo_fin, rem_fin, div_result;

    // Odd div opcodes are the unsigned variants, bit 1 selects remainder.
    assign div_signed = !bus.aluop_i[0];
    assign dvd_neg    = div_signed && bus.rs1_data_i[XLEN-1];
    assign dsr_neg    = div_signed && op2[XLEN-1];
    assign dvd_mag    = dvd_neg ? -bus.rs1_data_i : bus.rs1_data_i;
    assign dsr_mag    = dsr_neg ? -op2 : op2;

    // Restoring step: shift the next dividend bit into the partial remainder;
    // a clear borrow bit means the divisor fits and the quotient bit is 1.
    assign trial = {rem_q, quo_q[XLEN-1]};
    assign diff  = trial - {1'b0, dsr_q};

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            dsr_q        <= '0;
            neg_quo_q    <= 1'b0;
            neg_rem_q    <= 1'b0;
            div0_q       <= 1'b0;
            is_rem_q     <= 1'b0;
            div_store_q  <= '0;
            div_target_q <= '0;
            div_rd_q     <= '0;
            div_rw_q     <= 1'b0;
        end else if (accept && is_div) begin
            dsr_q        <= dsr_mag;
            neg_quo_q    <= dvd_neg ^ dsr_neg;
            neg_rem_q    <= dvd_neg;
            div0_q       <= op2 == '0;
            is_rem_q     <= bus.aluop_i[1];
            div_store_q  <= bus.rs2_data_i;
            div_target_q <= target;
            div_rd_q     <= bus.rd_i;
            div_rw_q     <= bus.regwrite_i;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        div_emit = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept && is_div) begin
                    state_d = S_DIV;
                    cnt_d   = SH_W'(XLEN - 1);
                    quo_d   = dvd_mag;
                    rem_d   = '0;
                end
            end
            S_DIV: begin
                quo_d = {quo_q[XLEN-2:0], !diff[XLEN]};
                rem_d = diff[XLEN] ? trial[XLEN-1:0] : diff[XLEN-1:0];
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                if (out_free) begin
                    div_emit = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (bus.flush_i) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            div_emit = 1'b0;
        end
    end

    // Overflow (most-negative / -1) falls out of the magnitude path naturally;
    // only divide-by-zero needs the quotient overridden.
    assign quo_fin    = div0_q ? '1 : (neg_quo_q ? -quo_q : quo_q);
    assign rem_fin    = neg_rem_q ? -rem_q : rem_q;
    assign div_result = is_rem_q ? rem_fin : quo_fin;

    assign idle       = state_q == S_IDLE;
    assign bus.busy_o = !idle;
`else
    assign idle       = 1'b1;
    assign div_emit   = 1'b0;
    assign bus.busy_o = 1'b0;
`endif

    // EX/MEM output register: flush wins, then a new load, then a drain.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            valid_q    <= 1'b0;
            result_q   <= '0;
            store_q    <= '0;
            target_q   <= '0;
            rd_q       <= '0;
            regwrite_q <= 1'b0;
            taken_q    <= 1'b0;
            illegal_q  <= 1'b0;
        end else if (bus.flush_i) begin
            valid_q <= 1'b0;
        end else if (accept && !is_div) begin
            valid_q    <= 1'b1;
            result_q   <= alu_res;
            store_q    <= bus.rs2_data_i;
            target_q   <= target;
            rd_q       <= bus.rd_i;
            regwrite_q <= rw_single;
            taken_q    <= taken;
            illegal_q  <= is_ill;
`ifdef EX_DIV_EN
        end else if (div_emit) begin
            valid_q    <= 1'b1;
            result_q   <= div_result;
            store_q    <= div_store_q;
            target_q   <= div_target_q;
            rd_q       <= div_rd_q;
            regwrite_q <= div_rw_q;
            taken_q    <= 1'b0;
            illegal_q  <= 1'b0;
`endif
        end else if (bus.ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.valid_o         = valid_q;
    assign bus.alu_result_o    = result_q;
    assign bus.rs2_data_o      = store_q;
    assign bus.branch_target_o = target_q;
    assign bus.rd_o            = rd_q;
    assign bus.regwrite_o      = regwrite_q;
    assign bus.branch_taken_o  = taken_q;
    assign bus.illegal_o       = illegal_q;
endmodule

// File: doc/execute_stage_mc.md
# execute_stage_mc

Parametrised, multi-cycle execute stage for the PSRV32 pipeline, sitting between the ID/EX and EX/MEM boundaries. It evaluates ALU and branch operations in one cycle and, when compiled in, RV32M-style divide/remainder operations over a fixed iterative latency. Valid/ready handshakes on both sides let it stall upstream and absorb downstream backpressure. Results, destination and store data are held in an internal EX/MEM output register.

## Interface
- XLEN, 32: datapath width, ≥8, power of two.
- RD_W, 5: register address width.
- clk_i  in  1  clock, rising edge.
- reset_ni  in  1  asynchronous, active-low reset.
- flush_i  in  1  kill in-flight and registered operation.
- valid_i  in  1  upstream operation valid.
- ready_o  out  1  stage can accept this cycle.
- pc_i  in  XLEN  PC of the instruction.
- rs1_data_i, rs2_data_i  in  XLEN  operands (OP1, OP2 register).
- offset_i  in  XLEN  sign-extended immediate/branch offset.
- aluop_i  in  5  operation code.
- alusrc_i  in  1  1: OP2 = offset_i; 0: OP2 = rs2_data_i.
- rd_i  in  RD_W  destination register; regwrite_i  in  1  write enable.
- valid_o  out  1  output register holds a result.
- ready_i  in  1  downstream accepts.
- alu_result_o, rs2_data_o, branch_target_o  out  XLEN  result, store data, pc_i+offset_i.
- rd_o  out  RD_W; regwrite_o, branch_taken_o, illegal_o, busy_o  out  1.

## Operation
- aluop: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 BEQ, 11 BNE, 12 BLT, 13 BGE, 14 BLTU, 15 BGEU, 16 DIV, 17 DIVU, 18 REM, 19 REMU, 20–31 illegal.
- Arithmetic modulo 2^XLEN; shift amount = OP2[log2(XLEN)-1:0]; SLT/SLTU return 0/1 zero-extended.
- Branches always compare rs1_data_i with rs2_data_i (alusrc_i ignored); branch_taken_o = compare result; alu_result_o = 0; regwrite_o forced 0.
- Illegal op: illegal_o=1, alu_result_o=0, regwrite_o=0, branch_taken_o=0; still a single-cycle op.
- Divide (restoring, one quotient bit per cycle, on magnitudes; signs fixed at end): divisor 0 → quotient all-ones, remainder = dividend; signed −2^(XLEN−1)/−1 → quotient = dividend, remainder 0. Special cases still take full latency.
- FSM: IDLE → (accept div op) DIV → (counter reaches 0) DONE → (output register free) IDLE. Single-cycle ops never leave IDLE.
- ready_o = (state==IDLE) && (!valid_o || ready_i) && !flush_i. Accept = valid_i && ready_o.
- busy_o = state != IDLE.

## Timing
- Reset (async assert, sync release): state IDLE, counter 0, all outputs 0, valid_o=0.
- Single-cycle op accepted at edge N: valid_o and payload visible after edge N.
- Div op accepted at edge N: DIV for XLEN cycles; DONE entered after edge N+XLEN; output loaded at edge N+XLEN+1 if register free, else held in DONE until it is.
- valid_o stays 1 and payload stable until an edge with ready_i=1; same edge may load the next result (back-to-back, full throughput for single-cycle ops).
- flush_i at an edge: valid_o→0, state→IDLE, divider aborted, no accept that edge; flush beats simultaneous valid_i and ready_i.
- Reset mid-division: immediate abort, no result produced.

## Configuration
- EX_DIV_EN defined: ops 16–19 use the iterative divider and FSM above.
- Not defined: divider, DIV/DONE states and counter omitted; ops 16–19 decode as illegal (single-cycle, illegal_o=1).

## Test plan
- Reset low mid-stream → all outputs 0, ready_o=1 after release with valid_i=0.
- ADD 0xFFFFFFFF+1, alusrc_i=0, rd=5 → valid_o next cycle, alu_result_o=0, rd_o=5, regwrite_o=1; SRA 0x80000000 by 0x21 → 0xC0000000.
- BLT rs1=−1, rs2=1 → branch_taken_o=1, branch_target_o=pc_i+offset_i, regwrite_o=0.
- EX_DIV_EN: DIV −7/2 → −3 after 33 cycles (XLEN=32), ready_o=0 throughout; REM −7/2 → −1; DIVU x/0 → 0xFFFFFFFF; DIV 0x80000000/−1 → 0x80000000.
- ready_i=0 for 5 cycles with valid_o=1 → payload stable, ready_o=0; release → next op accepted same edge.
- flush_i during DIV cycle 10 → valid_o=0, busy_o=0 next cycle, no result emitted; without EX_DIV_EN, op 16 → illegal_o=1.
